// File: rtl/rom_burst_reader_pkg.sv
// Shared types and table-generation helper for the ROM burst reader.
package rom_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

  // Rotate the low `width` bits of addr left by one. The caller resizes the result to the word width.
  function automatic logic [63:0] rotl1(input logic [63:0] addr, input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (((addr & mask) << 1) | ((addr & mask) >> (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// Host/consumer bundle of the ROM burst reader; rd_parity exists only when ROM_PARITY_EN is defined.
interface rom_burst_reader_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
);
  logic              ce_n;
  logic              oe_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              busy;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              done;
  logic              abort;
`ifdef ROM_PARITY_EN
  logic              rd_parity;
`endif

  modport master (
    output ce_n, oe_n, start, start_addr, burst_len, rd_ready,
    input  busy, rd_valid, rd_data, rd_addr, done, abort
`ifdef ROM_PARITY_EN
    , input rd_parity
`endif
  );

  modport slave (
    input  ce_n, oe_n, start, start_addr, burst_len, rd_ready,
    output busy, rd_valid, rd_data, rd_addr, done, abort
`ifdef ROM_PARITY_EN
    , output rd_parity
`endif
  );

endinterface

// File: rtl/rom_burst_reader_mem.sv
// Fixed lookup table (word[i] = rotl1(i)) with a single registered read port.
module rom_burst_mem
  import rom_burst_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = DATA_W'(rotl1(64'(g), ADDR_W));
  end

  // NOTE: the read register is deliberately not reset; the reader gates it to zero outside HOLD.
  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Handshaked burst reader over the lookup table, with active-low chip/output enables.
// Optional build macro: ROM_PARITY_EN adds rd_parity (XOR of rd_data).
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input logic               clk,
  input logic               rst,
  rom_burst_reader_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] mem_data;
  logic              beat_out;
  logic              xfer;

  rom_burst_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk (clk),
    .addr(addr_q),
    .data(mem_data)
  );

  // A deasserted chip enable wins over a same-cycle handshake, so the beat is never offered.
  assign beat_out = (state_q == HOLD) && !bus.oe_n && !bus.ce_n;
  assign xfer     = beat_out && bus.rd_ready;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.ce_n) begin
          addr_d  = bus.start_addr;
          rem_d   = bus.burst_len;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.ce_n) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          rd_addr_d = addr_q;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (bus.ce_n) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (xfer) begin
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_addr_q <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.rd_valid = beat_out;
  assign bus.rd_data  = beat_out ? mem_data : '0;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.done     = done_q;
  assign bus.abort    = abort_q;
`ifdef ROM_PARITY_EN
  assign bus.rd_parity = beat_out ? (^mem_data) : 1'b0;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench for rom_burst_reader: the driver queues expected beats, a negedge monitor checks them.
module tb_rom_burst_reader;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef struct {
    int addr;
    int data;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  rom_burst_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  rom_burst_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Table contents from the rule: rotate-left-by-one within a 4-bit index.
  function automatic int rom_word(input int a);
    return ((a * 2) % DEPTH) | (a / (DEPTH / 2));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every offered beat against the head of the expected queue.
  always @(negedge clk) begin
    logic [DATA_W-1:0] w;
    if (rst === 1'b0) begin
      check("done_abort_excl", 32'(bus.done & bus.abort), 32'd0);
      if (!bus.rd_valid) begin
        check("idle_data_zero", 32'(bus.rd_data), 32'd0);
`ifdef ROM_PARITY_EN
        check("idle_parity_zero", 32'(bus.rd_parity), 32'd0);
`endif
      end else if (!bus.ce_n) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr %0d data %0d expected no beat", bus.rd_addr, bus.rd_data);
        end else begin
          w = DATA_W'(exp_q[0].data);
          check("beat_addr", 32'(bus.rd_addr), 32'(exp_q[0].addr));
          check("beat_data", 32'(bus.rd_data), 32'(w));
`ifdef ROM_PARITY_EN
          check("beat_parity", 32'(bus.rd_parity), 32'(^w));
`endif
          if (bus.rd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic launch(input int a, input int len);
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.addr = (a + i) % DEPTH;
      b.data = rom_word(b.addr);
      exp_q.push_back(b);
    end
    bus.start_addr = ADDR_W'(a);
    bus.burst_len  = LEN_W'(len);
    bus.start      = 1'b1;
    bus.ce_n       = 1'b0;
    bus.oe_n       = 1'b0;
    tick();
    bus.start = 1'b0;
    check("lat_fetch_no_valid", 32'(bus.rd_valid), 32'd0);
    check("lat_busy", 32'(bus.busy), 32'd1);
    tick();
    check("lat_first_valid", 32'(bus.rd_valid), 32'd1);
  endtask

  // mode 0: always ready; 1: random ready/oe_n/spurious start; 2: ready low 5 cycles on beat 2; 3: oe_n high 3 cycles on beat 2.
  task automatic run_burst(input int a, input int len, input int mode);
    bit seen;
    seen = 1'b0;
    launch(a, len);
    for (int k = 0; k < 400 && !seen; k++) begin
      case (mode)
        1: begin
          bus.rd_ready   = 1'($urandom_range(0, 1));
          bus.oe_n       = ($urandom_range(0, 3) == 0);
          bus.start      = 1'($urandom_range(0, 1));
          bus.start_addr = ADDR_W'($urandom);
          bus.burst_len  = LEN_W'($urandom);
        end
        2: begin
          bus.rd_ready = !(k >= 2 && k <= 6);
          bus.oe_n     = 1'b0;
        end
        3: begin
          bus.rd_ready = 1'b1;
          bus.oe_n     = (k >= 2 && k <= 4);
        end
        default: begin
          bus.rd_ready = 1'b1;
          bus.oe_n     = 1'b0;
        end
      endcase
      if (mode == 3 && k >= 2 && k <= 4) begin
        #1;
        check("oe_stall_valid", 32'(bus.rd_valid), 32'd0);
        check("oe_stall_data", 32'(bus.rd_data), 32'd0);
      end
      tick();
      if (bus.done) seen = 1'b1;
    end
    bus.start    = 1'b0;
    bus.rd_ready = 1'b1;
    bus.oe_n     = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("done_busy_low", 32'(bus.busy), 32'd0);
    check("done_no_abort", 32'(bus.abort), 32'd0);
    check("all_beats_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    check("done_one_pulse", 32'(bus.done), 32'd0);
  endtask

  task automatic abort_burst();
    launch(5, 3);
    bus.rd_ready = 1'b1;
    tick();
    tick();
    bus.ce_n = 1'b1;
    tick();
    check("abort_pulse", 32'(bus.abort), 32'd1);
    check("abort_no_done", 32'(bus.done), 32'd0);
    check("abort_busy_low", 32'(bus.busy), 32'd0);
    check("abort_no_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_beats_left", 32'(exp_q.size()), 32'd3);
    bus.ce_n = 1'b0;
    exp_q.delete();
    tick();
    check("abort_one_pulse", 32'(bus.abort), 32'd0);
    check("abort_then_no_done", 32'(bus.done), 32'd0);
  endtask

  task automatic reset_mid_burst();
    launch(9, 3);
    bus.rd_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_data", 32'(bus.rd_data), 32'd0);
    check("rst_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_abort", 32'(bus.abort), 32'd0);
    rst = 1'b0;
    bus.rd_ready = 1'b1;
    exp_q.delete();
    tick();
    check("rst_after_done", 32'(bus.done), 32'd0);
    check("rst_after_abort", 32'(bus.abort), 32'd0);
    check("rst_after_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.ce_n       = 1'b1;
    bus.oe_n       = 1'b1;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.burst_len  = '0;
    bus.rd_ready   = 1'b1;
    tick();
    tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_abort", 32'(bus.abort), 32'd0);
    check("reset_data", 32'(bus.rd_data), 32'd0);
    check("reset_addr", 32'(bus.rd_addr), 32'd0);
    rst = 1'b0;

    // start while the chip is disabled must be ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_ce_high_ignored", 32'(bus.busy), 32'd0);
    bus.ce_n = 1'b0;
    bus.oe_n = 1'b0;
    tick();

    run_burst(3, 3, 0);
    run_burst(14, 3, 0);
    run_burst(0, 3, 2);
    run_burst(7, 3, 3);
    abort_burst();
    reset_mid_burst();
    run_burst(13, 0, 0);
    run_burst(10, 15, 0);
    for (int n = 0; n < 20; n++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2 ** LEN_W - 1)), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
